traffic_light_sequencer: RTL and testbench

- Phase controller for a two-road intersection: north-south (NS) and east-west (EW).
- Sequences the light phases from a one-second tick.
- Generates the per-direction remaining-seconds values (0-19) and the enable for the two Counter_decoder instances that drive the 2-digit countdown displays.
- Sits between the tick generator and the display decoders / lamp drivers.
- Provides a flashing-yellow night mode.

---
 rtl/traffic_light_if.sv | 13 +
 rtl/traffic_light_sequencer.sv | 100 ++++++++++
 tb/tb_traffic_light_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/traffic_light_if.sv
// traffic_light_if: sequencer control inputs and lamp/countdown outputs
interface traffic_light_if #(parameter int pNUMBER_WIDTH = 5);
    logic                     tick;
    logic                     en;
    logic                     flash;
    logic [2:0]               ns_light;
    logic [2:0]               ew_light;
    logic [pNUMBER_WIDTH-1:0] ns_count;
    logic [pNUMBER_WIDTH-1:0] ew_count;
    logic                     count_en;
    modport master (output tick, en, flash, input ns_light, ew_light, ns_count, ew_count, count_en);
    modport slave  (input tick, en, flash, output ns_light, ew_light, ns_count, ew_count, count_en);
endinterface

// File: rtl/traffic_light_sequencer.sv
// traffic_light_sequencer: two-road phase ring with countdowns and flashing-yellow night mode
module traffic_light_sequencer #(
    parameter int pNUMBER_WIDTH = 5,
    parameter int pGREEN_TIME   = 15,
    parameter int pYELLOW_TIME  = 3
) (
    input  logic clk,
    input  logic rst_n,
    traffic_light_if.slave bus
);
    if (pGREEN_TIME < 1 || pGREEN_TIME > 18 || pYELLOW_TIME < 1 || pYELLOW_TIME > 18 ||
        pGREEN_TIME + pYELLOW_TIME > 19) begin : g_bad_time
        $error("traffic_light_sequencer: green/yellow times exceed the 19-second display range");
    end

    localparam logic [pNUMBER_WIDTH-1:0] G = pNUMBER_WIDTH'(pGREEN_TIME);
    localparam logic [pNUMBER_WIDTH-1:0] Y = pNUMBER_WIDTH'(pYELLOW_TIME);

    typedef enum logic [2:0] {NS_GREEN, NS_YELLOW, EW_GREEN, EW_YELLOW, FLASH} state_t;

    state_t                   state, state_n;
    logic [pNUMBER_WIDTH-1:0] cnt, cnt_n;
    logic                     blink, blink_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= NS_GREEN;
            cnt   <= G;
            blink <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            blink <= blink_n;
        end
    end

    // flash dominates en, which dominates tick; leaving FLASH never waits for a tick
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        blink_n = blink;
        if (bus.flash) begin
            state_n = FLASH;
            blink_n = (state != FLASH) ? 1'b1 : blink ^ (bus.en & bus.tick);
        end else if (state == FLASH) begin
            state_n = NS_GREEN;
            cnt_n   = G;
            blink_n = 1'b1;
        end else if (bus.en && bus.tick) begin
            if (cnt > 1) begin
                cnt_n = cnt - 1'b1;
            end else begin
                state_n = (state == NS_GREEN)  ? NS_YELLOW :
                          (state == NS_YELLOW) ? EW_GREEN  :
                          (state == EW_GREEN)  ? EW_YELLOW : NS_GREEN;
                cnt_n   = (state == NS_GREEN || state == EW_GREEN) ? Y : G;
            end
        end
    end

    // red direction counts to its own green: opposing green plus opposing yellow
    always_comb begin
        bus.ns_light = 3'b000;
        bus.ew_light = 3'b000;
        bus.ns_count = '0;
        bus.ew_count = '0;
        bus.count_en = 1'b1;
        case (state)
            NS_GREEN: begin
                bus.ns_light = 3'b001;
                bus.ew_light = 3'b100;
                bus.ns_count = cnt;
                bus.ew_count = cnt + Y;
            end
            NS_YELLOW: begin
                bus.ns_light = 3'b010;
                bus.ew_light = 3'b100;
                bus.ns_count = cnt;
                bus.ew_count = cnt;
            end
            EW_GREEN: begin
                bus.ns_light = 3'b100;
                bus.ew_light = 3'b001;
                bus.ns_count = cnt + Y;
                bus.ew_count = cnt;
            end
            EW_YELLOW: begin
                bus.ns_light = 3'b100;
                bus.ew_light = 3'b010;
                bus.ns_count = cnt;
                bus.ew_count = cnt;
            end
            default: begin
                bus.ns_light = {1'b0, blink, 1'b0};
                bus.ew_light = {1'b0, blink, 1'b0};
                bus.count_en = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_traffic_light_sequencer.sv
// tb_traffic_light_sequencer: directed checks of phase ring, freeze, flash and async reset
module tb_traffic_light_sequencer;
    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   max2    = 0;
    int   min2    = 99;

    traffic_light_if #(.pNUMBER_WIDTH(5)) bus  ();
    traffic_light_if #(.pNUMBER_WIDTH(5)) bus2 ();

    traffic_light_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    traffic_light_sequencer #(.pGREEN_TIME(16), .pYELLOW_TIME(3)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (int'(bus2.ns_count) > max2) max2 = int'(bus2.ns_count);
            if (int'(bus2.ew_count) > max2) max2 = int'(bus2.ew_count);
            if (int'(bus2.ns_count) < min2) min2 = int'(bus2.ns_count);
            if (int'(bus2.ew_count) < min2) min2 = int'(bus2.ew_count);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.tick  = 1'b1;
            bus2.tick = 1'b1;
            @(negedge clk);
            bus.tick  = 1'b0;
            bus2.tick = 1'b0;
        end
    endtask

    task automatic check_state(input string tag, input int nl, input int el, input int nc, input int ec, input int ce);
        check({tag, ".ns_light"}, bus.ns_light, nl);
        check({tag, ".ew_light"}, bus.ew_light, el);
        check({tag, ".ns_count"}, bus.ns_count, nc);
        check({tag, ".ew_count"}, bus.ew_count, ec);
        check({tag, ".count_en"}, bus.count_en, ce);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.tick = 1'b0;  bus.en = 1'b1;  bus.flash = 1'b0;
        bus2.tick = 1'b0; bus2.en = 1'b1; bus2.flash = 1'b0;
        do_tick(1);
        check_state("reset", 3'b001, 3'b100, 15, 18, 1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        do_tick(1);
        check_state("t1", 3'b001, 3'b100, 14, 17, 1);
        do_tick(14);
        check_state("t15", 3'b010, 3'b100, 3, 3, 1);
        do_tick(3);
        check_state("t18", 3'b100, 3'b001, 18, 15, 1);
        do_tick(14);
        check_state("t32", 3'b100, 3'b001, 4, 1, 1);
        do_tick(1);
        check_state("t33", 3'b100, 3'b010, 3, 3, 1);
        do_tick(3);
        check_state("t36", 3'b001, 3'b100, 15, 18, 1);
        do_tick(8);
        check("pre_freeze.ns_count", bus.ns_count, 7);
        bus.en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.tick = (i % 2 == 0);
        end
        @(negedge clk);
        bus.tick = 1'b0;
        check_state("frozen", 3'b001, 3'b100, 7, 10, 1);
        bus.en = 1'b1;
        do_tick(1);
        check("resume.ns_count", bus.ns_count, 6);
        do_tick(9);
        check_state("ew_green", 3'b100, 3'b001, 18, 15, 1);
        @(negedge clk);
        bus.tick  = 1'b1;
        bus.flash = 1'b1;
        @(negedge clk);
        bus.tick  = 1'b0;
        check_state("flash_in", 3'b010, 3'b010, 0, 0, 0);
        do_tick(1);
        check_state("flash_off1", 3'b000, 3'b000, 0, 0, 0);
        do_tick(1);
        check_state("flash_on", 3'b010, 3'b010, 0, 0, 0);
        do_tick(1);
        check_state("flash_off2", 3'b000, 3'b000, 0, 0, 0);
        bus.en = 1'b0;
        do_tick(2);
        check("flash_en0.ns_light", bus.ns_light, 3'b000);
        bus.en = 1'b1;
        @(negedge clk);
        bus.flash = 1'b0;
        @(negedge clk);
        check_state("flash_out", 3'b001, 3'b100, 15, 18, 1);
        do_tick(33);
        check_state("ew_yellow", 3'b100, 3'b010, 3, 3, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_state("async_rst", 3'b001, 3'b100, 15, 18, 1);
        @(negedge clk);
        rst_n = 1'b1;
        check("g16y3.max", max2, 19);
        check("g16y3.min", min2, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
